// File: rtl/trng_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trng_pkg                                                         |
// | Purpose  : Shared constants and reader FSM state encoding for TRNG readback |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package trng_pkg;

    localparam int TRNG_ADDR_W     = 10;
    localparam int TRNG_DATA_W     = 64;
    localparam int TRNG_MAX_WORDS  = 512;
    localparam int TRNG_RD_LAT     = 2;
    localparam int TRNG_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/trng_rd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trng_rd_fifo                                                     |
// | Purpose  : First-word-fall-through skid FIFO for returned BRAM read data    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module trng_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rd_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_pop;

    assign w_pop = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/trng_bram_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trng_bram_reader                                                 |
// | Purpose  : Streams TRNG words out of BRAM over valid/ready with credits     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module trng_bram_reader
    import trng_pkg::*;
#(
    parameter int ADDR_W     = TRNG_ADDR_W,
    parameter int DATA_W     = TRNG_DATA_W,
    parameter int RD_LAT     = TRNG_RD_LAT,
    parameter int FIFO_DEPTH = TRNG_FIFO_DEPTH,
    parameter int MAX_WORDS  = TRNG_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rd_rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] num_words_i,
    output logic              bram_en_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    input  logic [DATA_W-1:0] bram_dout_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] words_sent_o
);

    localparam int                CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int                OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
    localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(MAX_WORDS);

    rd_state_e         state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sent_q;
    logic              en_q;
    logic              busy_q;
    logic              done_q;
    logic [RD_LAT-1:0] vld_q;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_head;
    logic [ADDR_W-1:0] w_n;
    logic [OCC_W-1:0]  w_inflight;
    logic [OCC_W-1:0]  w_occ;
    logic              w_credit;
    logic              w_last;
    logic              w_accept;

    // Read-valid pipeline; its tail lines up with the cycle bram_dout is valid.
    generate
        if (RD_LAT == 1) begin : g_vld_lat1
            always_ff @(posedge clk) begin
                if (rd_rst) vld_q <= '0;
                else        vld_q <= en_q;
            end
        end else begin : g_vld_latn
            always_ff @(posedge clk) begin
                if (rd_rst) vld_q <= '0;
                else        vld_q <= {vld_q[RD_LAT-2:0], en_q};
            end
        end
    endgenerate

    assign w_push = vld_q[RD_LAT-1];
    assign w_pop  = !w_empty && m_ready_i;

    trng_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rd_rst  (rd_rst),
        .push_i  (w_push),
        .data_i  (bram_dout_i),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Outstanding words = buffered + reads still in the BRAM pipe (incl. this cycle's).
    always_comb begin
        w_inflight = OCC_W'(en_q);
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + OCC_W'(vld_q[i]);
        end
    end

    assign w_occ    = OCC_W'(w_count) + w_inflight;
    assign w_credit = w_occ < (OCC_W'(FIFO_DEPTH) + OCC_W'(w_pop));
    assign w_n      = (num_words_i > MAX_N) ? MAX_N : num_words_i;
    assign w_last   = !w_empty && (sent_q == n_q - ADDR_W'(1));
    assign w_accept = start_i && ((state_q == RD_IDLE) || (state_q == RD_DONE));

    always_ff @(posedge clk) begin
        if (rd_rst) begin
            state_q <= RD_IDLE;
            base_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            sent_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE, RD_DONE: begin
                    en_q <= 1'b0;
                    if (w_accept) begin
                        base_q <= base_addr_i;
                        n_q    <= w_n;
                        sent_q <= '0;
                        if (w_n == '0) begin
                            state_q <= RD_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            // First read goes out on the accepting edge to save a cycle.
                            state_q <= RD_ISSUE;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            en_q    <= 1'b1;
                            addr_q  <= base_addr_i;
                            idx_q   <= ADDR_W'(1);
                        end
                    end
                end
                RD_ISSUE: begin
                    if (idx_q == n_q) begin
                        en_q    <= 1'b0;
                        state_q <= RD_DRAIN;
                    end else if (w_credit) begin
                        en_q   <= 1'b1;
                        addr_q <= base_q + idx_q;
                        idx_q  <= idx_q + ADDR_W'(1);
                    end else begin
                        en_q <= 1'b0;
                    end
                end
                RD_DRAIN: begin
                    en_q <= 1'b0;
                end
                default: begin
                    state_q <= RD_IDLE;
                    en_q    <= 1'b0;
                end
            endcase

            if (w_pop) begin
                sent_q <= sent_q + ADDR_W'(1);
                if (w_last) begin
                    state_q <= RD_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rd_rst) begin
            assert (!(w_push && w_full));
        end
    end

    assign bram_en_o    = en_q;
    assign bram_addr_o  = addr_q;
    assign m_valid_o    = !w_empty;
    assign m_data_o     = w_empty ? '0 : w_head;
    assign m_last_o     = w_last;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign words_sent_o = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_bram_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_trng_bram_reader                                              |
// | Purpose  : Directed self-checking bench for trng_bram_reader                |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_trng_bram_reader;

    logic        clk        = 1'b0;
    logic        rd_rst     = 1'b1;
    logic        start      = 1'b0;
    logic [9:0]  base_addr  = '0;
    logic [9:0]  num_words  = '0;
    logic        bram_en;
    logic [9:0]  bram_addr;
    logic [63:0] bram_dout  = '0;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready    = 1'b0;
    logic        m_last;
    logic        busy;
    logic        done;
    logic [9:0]  words_sent;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    trng_bram_reader dut (
        .clk          (clk),
        .rd_rst       (rd_rst),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .num_words_i  (num_words),
        .bram_en_o    (bram_en),
        .bram_addr_o  (bram_addr),
        .bram_dout_i  (bram_dout),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last),
        .busy_o       (busy),
        .done_o       (done),
        .words_sent_o (words_sent)
    );

    // Two-stage BRAM with mem[i] = i
    logic [63:0] bram_p1 = '0;
    always @(posedge clk) begin
        if (bram_en) bram_p1 <= 64'(bram_addr);
        bram_dout <= bram_p1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [9:0] b, input logic [9:0] n);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < maxc) begin
            tick();
            cyc++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    // Monitor: records issued addresses, accepted words, and outstanding depth
    logic [63:0] got   [$];
    logic [9:0]  addrs [$];
    logic        lasts [$];
    int          iss_cnt    = 0;
    int          acc_cnt    = 0;
    int          max_out    = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    always @(negedge clk) begin
        if (rd_rst) begin
            iss_cnt    = 0;
            acc_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", m_data, prev_data);
            end
            if (bram_en) begin
                addrs.push_back(bram_addr);
                iss_cnt++;
            end
            if (iss_cnt - acc_cnt > max_out) max_out = iss_cnt - acc_cnt;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                lasts.push_back(m_last);
                acc_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    int g0, a0, cyc, lat, errs;
    logic [9:0] ea;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_en", 64'(bram_en), 64'd0);
        chk("rst_addr", 64'(bram_addr), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", m_data, 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sent", 64'(words_sent), 64'd0);
        rd_rst = 1'b0;
        tick();

        // Back-to-back: base 16, n 8
        m_ready = 1'b1;
        g0 = got.size();
        a0 = addrs.size();
        pulse_start(10'd16, 10'd8);
        chk("b2b_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!m_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b_latency", 64'(lat), 64'd3);
        chk("b2b_first", m_data, 64'd16);
        wait_done(100, "b2b_done", cyc);
        chk("b2b_total_cycles", 64'(lat + cyc), 64'd11);
        chk("b2b_count", 64'(got.size() - g0), 64'd8);
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            if (got[g0 + i] !== 64'(16 + i)) errs++;
            if (lasts[g0 + i] !== (i == 7)) errs++;
            if (addrs[a0 + i] !== 10'(16 + i)) errs++;
        end
        chk("b2b_seq", 64'(errs), 64'd0);
        chk("b2b_sent", 64'(words_sent), 64'd8);
        chk("b2b_busy_end", 64'(busy), 64'd0);

        // Backpressure: base 0, n 20
        g0 = got.size();
        pulse_start(10'd0, 10'd20);
        for (int i = 0; i < 12; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        m_ready = 1'b0;
        repeat (10) tick();
        chk("bp_stall_en", 64'(bram_en), 64'd0);
        chk("bp_stall_valid", 64'(m_valid), 64'd1);
        chk("bp_max_outstanding", 64'(max_out), 64'd4);
        m_ready = 1'b1;
        wait_done(100, "bp_done", cyc);
        chk("bp_count", 64'(got.size() - g0), 64'd20);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (got[g0 + i] !== 64'(i)) errs++;
            if (lasts[g0 + i] !== (i == 19)) errs++;
        end
        chk("bp_seq", 64'(errs), 64'd0);
        chk("bp_sent", 64'(words_sent), 64'd20);

        // Address wrap: base 1020, n 6
        g0 = got.size();
        a0 = addrs.size();
        pulse_start(10'd1020, 10'd6);
        wait_done(100, "wrap_done", cyc);
        chk("wrap_count", 64'(got.size() - g0), 64'd6);
        chk("wrap_issues", 64'(addrs.size() - a0), 64'd6);
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            ea = 10'(1020 + i);
            if (addrs[a0 + i] !== ea) errs++;
            if (got[g0 + i] !== 64'(ea)) errs++;
        end
        chk("wrap_seq", 64'(errs), 64'd0);

        // Zero-length call after a fresh reset
        rd_rst = 1'b1;
        tick();
        rd_rst = 1'b0;
        chk("zero_pre_done", 64'(done), 64'd0);
        a0 = addrs.size();
        pulse_start(10'd5, 10'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("zero_no_issue", 64'(addrs.size() - a0), 64'd0);
        chk("zero_sent", 64'(words_sent), 64'd0);

        // Clamp: n 700 -> 512 words
        g0 = got.size();
        pulse_start(10'd200, 10'd700);
        wait_done(700, "clamp_done", cyc);
        chk("clamp_count", 64'(got.size() - g0), 64'd512);
        errs = 0;
        for (int i = 0; i < 512 && (g0 + i) < got.size(); i++) begin
            if (got[g0 + i] !== 64'(200 + i)) errs++;
            if (lasts[g0 + i] !== (i == 511)) errs++;
        end
        chk("clamp_seq", 64'(errs), 64'd0);
        chk("clamp_sent", 64'(words_sent), 64'd512);

        // Start while busy is ignored
        g0 = got.size();
        a0 = addrs.size();
        pulse_start(10'd40, 10'd10);
        tick();
        tick();
        pulse_start(10'd500, 10'd4);
        wait_done(100, "busy_done", cyc);
        chk("busy_count", 64'(got.size() - g0), 64'd10);
        chk("busy_issues", 64'(addrs.size() - a0), 64'd10);
        errs = 0;
        for (int i = 0; i < 10 && (g0 + i) < got.size(); i++) begin
            if (got[g0 + i] !== 64'(40 + i)) errs++;
        end
        for (int i = 0; i < 10 && (a0 + i) < addrs.size(); i++) begin
            if (addrs[a0 + i] !== 10'(40 + i)) errs++;
        end
        chk("busy_seq", 64'(errs), 64'd0);
        chk("busy_sent", 64'(words_sent), 64'd10);

        // Reset mid-call after 5 of 10 words
        g0 = got.size();
        pulse_start(10'd0, 10'd10);
        cyc = 0;
        while ((got.size() - g0) < 5 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("mid_reached5", 64'(got.size() - g0), 64'd5);
        rd_rst = 1'b1;
        tick();
        chk("mid_en", 64'(bram_en), 64'd0);
        chk("mid_addr", 64'(bram_addr), 64'd0);
        chk("mid_valid", 64'(m_valid), 64'd0);
        chk("mid_data", m_data, 64'd0);
        chk("mid_last", 64'(m_last), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_sent", 64'(words_sent), 64'd0);
        rd_rst = 1'b0;
        tick();
        g0 = got.size();
        pulse_start(10'd100, 10'd3);
        wait_done(100, "post_done", cyc);
        chk("post_count", 64'(got.size() - g0), 64'd3);
        errs = 0;
        for (int i = 0; i < 3 && (g0 + i) < got.size(); i++) begin
            if (got[g0 + i] !== 64'(100 + i)) errs++;
            if (lasts[g0 + i] !== (i == 2)) errs++;
        end
        chk("post_seq", 64'(errs), 64'd0);
        chk("final_max_outstanding", 64'(max_out), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
